// File: rtl/i2s_pkg.sv
// Shared definitions for the slave-mode I2S transceiver: default widths and channel encoding.
package i2s_pkg;
    localparam int D_WIDTH_DEF     = 24;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } ch_e;
endpackage

// File: rtl/i2s_edge_sync.sv
// Multi-flop synchronizer for an asynchronous clock-like input, with registered
// one-cycle rise/fall pulses taken from the synchronized level.
module i2s_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_p;
    logic              level_p;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p  <= '0;
            level_p <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync_p  <= {sync_p[STAGES-2:0], d};
            level_p <= sync_p[STAGES-1];
            rise    <= sync_p[STAGES-1] & ~level_p;
            fall    <= ~sync_p[STAGES-1] & level_p;
        end
    end
endmodule

// File: rtl/i2s_slave_transceiver.sv
// Slave-side Philips I2S transceiver: oversamples sclk/ws/sd_rx in the mclk domain,
// deserializes L/R slots into parallel words and serializes parallel words onto sd_tx.
module i2s_slave_transceiver
    import i2s_pkg::*;
#(
    parameter int D_WIDTH     = D_WIDTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic               mclk,
    input  logic               reset,
    input  logic               sclk,
    input  logic               ws,
    input  logic               sd_rx,
    output logic               sd_tx,
    input  logic [D_WIDTH-1:0] l_data_tx,
    input  logic [D_WIDTH-1:0] r_data_tx,
    output logic               tx_load,
    output logic [D_WIDTH-1:0] l_data_rx,
    output logic [D_WIDTH-1:0] r_data_rx,
    output logic               rx_valid,
    output logic               rx_short
);
    localparam int CNT_W = $clog2(D_WIDTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(D_WIDTH);

    logic                   rise, fall;
    logic [SYNC_STAGES-1:0] ws_sync_p, sd_sync_p;
    logic                   ws_s, sd_s;

    logic                   have_ws, locked;
    ch_e                    ws_q, tx_ch;
    logic [CNT_W-1:0]       bcnt, tx_cnt;
    logic [D_WIDTH-1:0]     rx_sh, tx_l_sh, tx_r_sh;
    logic [D_WIDTH-1:0]     rx_word;
    logic [CNT_W-1:0]       rx_n;
    logic                   boundary;

    function automatic logic [D_WIDTH-1:0] msb_align(input logic [D_WIDTH-1:0] w,
                                                     input logic [CNT_W-1:0]   n);
        return w << (FULL - n);
    endfunction

    i2s_edge_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk   (mclk),
        .reset (reset),
        .d     (sclk),
        .rise  (rise),
        .fall  (fall)
    );

    // ws and sd_rx get the same depth as sclk so their relative timing survives.
    always_ff @(posedge mclk) begin
        if (reset) begin
            ws_sync_p <= '0;
            sd_sync_p <= '0;
        end else begin
            ws_sync_p <= {ws_sync_p[SYNC_STAGES-2:0], ws};
            sd_sync_p <= {sd_sync_p[SYNC_STAGES-2:0], sd_rx};
        end
    end

    assign ws_s = ws_sync_p[SYNC_STAGES-1];
    assign sd_s = sd_sync_p[SYNC_STAGES-1];

    // The first rise after reset only captures ws, so a reset inside a slot
    // cannot fake a boundary.
    assign boundary = rise && have_ws && (ws_q != ch_e'(ws_s));

    always_comb begin
        rx_word = rx_sh;
        rx_n    = bcnt;
        if (bcnt < FULL) begin
            rx_word = {rx_sh[D_WIDTH-2:0], sd_s};
            rx_n    = bcnt + CNT_W'(1);
        end
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            sd_tx     <= 1'b0;
            tx_load   <= 1'b0;
            l_data_rx <= '0;
            r_data_rx <= '0;
            rx_valid  <= 1'b0;
            rx_short  <= 1'b0;
            have_ws   <= 1'b0;
            locked    <= 1'b0;
            ws_q      <= CH_LEFT;
            tx_ch     <= CH_LEFT;
            bcnt      <= '0;
            tx_cnt    <= '0;
            rx_sh     <= '0;
            tx_l_sh   <= '0;
            tx_r_sh   <= '0;
        end else begin
            tx_load  <= 1'b0;
            rx_valid <= 1'b0;
            rx_short <= 1'b0;

            if (rise) begin
                ws_q    <= ch_e'(ws_s);
                have_ws <= 1'b1;
                if (boundary) begin
                    if (locked) begin
                        if (ws_q == CH_LEFT) begin
                            l_data_rx <= msb_align(rx_word, rx_n);
                        end else begin
                            r_data_rx <= msb_align(rx_word, rx_n);
                            rx_valid  <= 1'b1;
                        end
                        rx_short <= (rx_n < FULL);
                    end
                    if (!locked || ws_q == CH_RIGHT) begin
                        tx_l_sh <= l_data_tx;
                        tx_r_sh <= r_data_tx;
                        tx_load <= 1'b1;
                    end
                    locked <= 1'b1;
                    tx_ch  <= ch_e'(ws_s);
                    tx_cnt <= '0;
                    bcnt   <= '0;
                    rx_sh  <= '0;
                end else begin
                    rx_sh <= rx_word;
                    bcnt  <= rx_n;
                end
            end

            // MSB goes out on the first fall after a boundary, zeros once the word is spent.
            if (fall && locked) begin
                if (tx_cnt < FULL) begin
                    if (tx_ch == CH_LEFT) begin
                        sd_tx   <= tx_l_sh[D_WIDTH-1];
                        tx_l_sh <= tx_l_sh << 1;
                    end else begin
                        sd_tx   <= tx_r_sh[D_WIDTH-1];
                        tx_r_sh <= tx_r_sh << 1;
                    end
                    tx_cnt <= tx_cnt + CNT_W'(1);
                end else begin
                    sd_tx <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_slave_transceiver.sv
// Directed bench: an I2S master at mclk/8 drives ws/sd_rx, decodes sd_tx and checks the parallel side.
module tb_i2s_slave_transceiver;
    localparam int DW = 24;

    logic          mclk = 1'b0;
    logic          reset = 1'b1;
    logic          sclk = 1'b0;
    logic          ws = 1'b0;
    logic          sd_drv = 1'b0;
    logic          loop = 1'b0;
    logic          sd_rx_pin;
    logic          sd_tx, tx_load, rx_valid, rx_short;
    logic [DW-1:0] l_data_tx = '0;
    logic [DW-1:0] r_data_tx = '0;
    logic [DW-1:0] l_data_rx, r_data_rx;

    int            checks = 0;
    int            errors = 0;
    int            n_valid = 0;
    int            n_short = 0;
    int            n_load = 0;
    int            pad_ones = 0;
    logic          pending = 1'b0;
    logic [DW-1:0] q_slot = '0;

    assign sd_rx_pin = loop ? sd_tx : sd_drv;

    i2s_slave_transceiver #(.D_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .mclk      (mclk),
        .reset     (reset),
        .sclk      (sclk),
        .ws        (ws),
        .sd_rx     (sd_rx_pin),
        .sd_tx     (sd_tx),
        .l_data_tx (l_data_tx),
        .r_data_tx (r_data_tx),
        .tx_load   (tx_load),
        .l_data_rx (l_data_rx),
        .r_data_rx (r_data_rx),
        .rx_valid  (rx_valid),
        .rx_short  (rx_short)
    );

    always #5 mclk = ~mclk;

    always @(posedge mclk) begin
        if (rx_valid) n_valid++;
        if (rx_short) n_short++;
        if (tx_load)  n_load++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic slot_bit(input logic [DW-1:0] word, input int w, input int k);
        logic [DW-1:0] t;
        if (k >= w) return 1'b0;
        t = word >> (w - 1 - k);
        return t[0];
    endfunction

    // One sclk period: drive on the fall, sample sd_tx just before the rise.
    task automatic bit_period(input logic w, input logic d, output logic q);
        sclk = 1'b0; ws = w; sd_drv = d;
        repeat (4) @(posedge mclk);
        #1;
        q = sd_tx;
        sclk = 1'b1;
        repeat (4) @(posedge mclk);
        #1;
    endtask

    // Periods p_lo..p_hi-1 of an n-period slot carrying a w-bit word (Philips one-bit delay).
    task automatic send_slot(input logic ch, input logic [DW-1:0] word, input int n,
                             input int w, input int p_lo, input int p_hi);
        logic q;
        for (int p = p_lo; p < p_hi; p++) begin
            bit_period(ch, (p == 0) ? pending : slot_bit(word, w, p - 1), q);
            if (p >= 1 && p <= DW) q_slot = {q_slot[DW-2:0], q};
            else if (p > DW && q !== 1'b0) pad_ones++;
        end
        if (p_hi == n) pending = slot_bit(word, w, n - 1);
    endtask

    initial begin
        logic [DW-1:0] ql, qr, x, y, prev_y;
        int v0, s0, l0;

        @(posedge mclk); #1;
        repeat (4) @(posedge mclk);
        #1;
        check("reset_sd_tx",     {31'h0, sd_tx},     32'h0);
        check("reset_tx_load",   {31'h0, tx_load},   32'h0);
        check("reset_l_data_rx", {8'h0, l_data_rx},  32'h0);
        check("reset_r_data_rx", {8'h0, r_data_rx},  32'h0);
        check("reset_rx_valid",  {31'h0, rx_valid},  32'h0);
        check("reset_rx_short",  {31'h0, rx_short},  32'h0);
        reset = 1'b0;
        l_data_tx = 24'h123456;
        r_data_tx = 24'hFEDCBA;

        // Frame 1: lock happens at the L->R boundary
        send_slot(1'b0, 24'hA5A5A5, 32, 24, 0, 32); ql = q_slot;
        send_slot(1'b1, 24'h5A5A5A, 32, 24, 0, 32); qr = q_slot;
        check("f1_tx_left_unlocked", {8'h0, ql}, 32'h0);
        check("f1_tx_right",         {8'h0, qr}, 32'h00FEDCBA);
        check("f1_rx_valid_count",   32'(n_valid), 32'd0);
        check("f1_tx_load_count",    32'(n_load), 32'd1);

        // Frame 2: full L/R pair received
        send_slot(1'b0, 24'hA5A5A5, 32, 24, 0, 32); ql = q_slot;
        send_slot(1'b1, 24'h5A5A5A, 32, 24, 0, 32); qr = q_slot;
        check("f2_l_data_rx",      {8'h0, l_data_rx}, 32'h00A5A5A5);
        check("f2_r_data_rx",      {8'h0, r_data_rx}, 32'h005A5A5A);
        check("f2_rx_valid_count", 32'(n_valid), 32'd1);
        check("f2_tx_left",        {8'h0, ql}, 32'h00123456);
        check("f2_tx_right",       {8'h0, qr}, 32'h00FEDCBA);
        check("f2_tx_load_count",  32'(n_load), 32'd2);
        check("f2_rx_short_count", 32'(n_short), 32'd0);

        // Frame 3: l_data_tx changes between the slots
        send_slot(1'b0, 24'hA5A5A5, 32, 24, 0, 32); ql = q_slot;
        l_data_tx = 24'h654321;
        l0 = n_load;
        send_slot(1'b1, 24'h5A5A5A, 32, 24, 0, 32);
        check("f3_tx_left_old",     {8'h0, ql}, 32'h00123456);
        check("f3_no_load_in_right", 32'(n_load - l0), 32'd0);
        check("f3_rx_valid_count",   32'(n_valid), 32'd2);
        l0 = n_load;
        send_slot(1'b0, 24'hA5A5A5, 32, 24, 0, 32); ql = q_slot;
        check("f4_load_at_r2l",   32'(n_load - l0), 32'd1);
        check("f4_tx_left_new",   {8'h0, ql}, 32'h00654321);
        send_slot(1'b1, 24'h5A5A5A, 32, 24, 0, 32); qr = q_slot;
        check("f4_tx_right",      {8'h0, qr}, 32'h00FEDCBA);
        check("pad_bits_zero",    32'(pad_ones), 32'd0);

        // Short slots: 16 sclk per channel
        send_slot(1'b0, 24'h00BEEF, 16, 16, 0, 16);
        send_slot(1'b1, 24'h001234, 16, 16, 0, 16);
        s0 = n_short; v0 = n_valid;
        send_slot(1'b0, 24'h00BEEF, 16, 16, 0, 16);
        send_slot(1'b1, 24'h001234, 16, 16, 0, 16);
        check("short_l_data_rx",  {8'h0, l_data_rx}, 32'h00BEEF00);
        check("short_r_data_rx",  {8'h0, r_data_rx}, 32'h00123400);
        check("short_pulses",     32'(n_short - s0), 32'd2);
        check("short_valid",      32'(n_valid - v0), 32'd1);

        // Reset at bit 10 of a right slot
        send_slot(1'b0, 24'h111111, 32, 24, 0, 32);
        send_slot(1'b1, 24'h222222, 32, 24, 0, 32);
        send_slot(1'b0, 24'h333333, 32, 24, 0, 32);
        send_slot(1'b1, 24'h222222, 32, 24, 0, 10);
        reset = 1'b1;
        repeat (3) @(posedge mclk);
        #1;
        check("midreset_sd_tx",     {31'h0, sd_tx},    32'h0);
        check("midreset_l_data_rx", {8'h0, l_data_rx}, 32'h0);
        check("midreset_r_data_rx", {8'h0, r_data_rx}, 32'h0);
        check("midreset_tx_load",   {31'h0, tx_load},  32'h0);
        reset = 1'b0;
        v0 = n_valid;
        send_slot(1'b1, 24'h222222, 32, 24, 10, 32);
        send_slot(1'b0, 24'h444444, 32, 24, 0, 32);
        send_slot(1'b1, 24'h555555, 32, 24, 0, 32);
        check("relock_l_data_rx", {8'h0, l_data_rx}, 32'h00444444);
        check("relock_r_data_rx", {8'h0, r_data_rx}, 32'h0);
        check("relock_no_valid",  32'(n_valid - v0), 32'd0);
        send_slot(1'b0, 24'h666666, 32, 24, 0, 32); ql = q_slot;
        send_slot(1'b1, 24'h777777, 32, 24, 0, 32);
        check("relock2_l_data_rx", {8'h0, l_data_rx}, 32'h00666666);
        check("relock2_r_data_rx", {8'h0, r_data_rx}, 32'h00555555);
        check("relock2_valid",     32'(n_valid - v0), 32'd1);
        check("relock2_tx_left",   {8'h0, ql}, 32'h00654321);

        // Loopback sd_tx -> sd_rx with random words
        loop = 1'b1;
        prev_y = '0;
        for (int j = 0; j < 100; j++) begin
            x = 24'($urandom);
            y = 24'($urandom);
            l_data_tx = x;
            r_data_tx = y;
            send_slot(1'b0, 24'h0, 32, 24, 0, 32);
            send_slot(1'b1, 24'h0, 32, 24, 0, 32);
            check("loop_l_data_rx", {8'h0, l_data_rx}, {8'h0, x});
            if (j > 0) check("loop_r_data_rx", {8'h0, r_data_rx}, {8'h0, prev_y});
            prev_y = y;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
